// File: rtl/bu2020_pkg.sv
// Shared constants and FSM state type for the memory responder block.
package bu2020_pkg;

  // Default bus widths used by the responder and its storage.
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  // Wait-state counter width; WAIT_CYCLES must fit in it (0..15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, asynchronous read, never reset.
module mem_array #(
  parameter int ADDR_W = bu2020_pkg::ADDR_W,
  parameter int DATA_W = bu2020_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Every address maps to its own word; no aliasing or wrap.
  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  // Commit a write on the rising edge when enabled; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_responder.sv
// Memory target: latches a request in IDLE, inserts WAIT_CYCLES wait states,
// then answers for one RESPOND cycle (read data on the shared bus, or a write
// committed at the end of that cycle).
module memory_responder #(
  parameter int ADDR_W      = bu2020_pkg::ADDR_W,
  parameter int DATA_W      = bu2020_pkg::DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Memory_addressbus,
  inout  wire  [DATA_W-1:0] Memory_databus,
  input  logic              Memory_writemode,
  input  logic              Memory_request,
  output logic              Memory_ready
);

  import bu2020_pkg::*;

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  mem_state_t        r_state, w_state_next;
  logic [CNT_W-1:0]  r_count, w_count_next;
  logic [ADDR_W-1:0] r_addr_q, w_addr_next;
  logic              r_we_q, w_we_next;
  logic [DATA_W-1:0] r_data_q, w_data_next;

  logic              w_oe;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_rd_data;

  // State and transaction capture registers; reset drops any pending work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_addr_q <= '0;
      r_we_q   <= 1'b0;
      r_data_q <= '0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_addr_q <= w_addr_next;
      r_we_q   <= w_we_next;
      r_data_q <= w_data_next;
    end
  end

  // Next-state and outputs; bus inputs only matter while IDLE.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_addr_next  = r_addr_q;
    w_we_next    = r_we_q;
    w_data_next  = r_data_q;
    Memory_ready = 1'b0;
    w_oe         = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      IDLE: begin
        if (Memory_request) begin
          w_addr_next  = Memory_addressbus;
          w_we_next    = Memory_writemode;
          if (Memory_writemode) begin
            w_data_next = Memory_databus;
          end
          w_count_next = WAIT_LOAD;
          w_state_next = (WAIT_LOAD != '0) ? WAIT : RESPOND;
        end
      end
      WAIT: begin
        // Counter is only loaded in IDLE with a non-zero value, so it never underflows.
        w_count_next = r_count - 1'b1;
        if (r_count == CNT_W'(1)) begin
          w_state_next = RESPOND;
        end
      end
      RESPOND: begin
        Memory_ready = 1'b1;
        w_oe         = !r_we_q;
        w_mem_we     = r_we_q;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (r_addr_q),
    .i_wdata (r_data_q),
    .o_rdata (w_rd_data)
  );

  // Bus is driven only during a read response.
  assign Memory_databus = w_oe ? w_rd_data : {DATA_W{1'bz}};

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_W, default 12, address bus width.
REQ-002 Parameter DATA_W, default 16, data bus width.
REQ-003 Parameter WAIT_CYCLES, default 2, wait states inserted per transaction; legal range 0..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Memory_addressbus  input  ADDR_W  word address from initiator.
REQ-007 Memory_databus  inout  DATA_W  write data in; read data driven out only during a read response.
REQ-008 Memory_writemode  input  1  1 = write, 0 = read.
REQ-009 Memory_request  input  1  initiator transaction strobe.
REQ-010 Memory_ready  output  1  one-cycle completion pulse.

Function
REQ-011 Storage SHALL be 2**ADDR_W words of DATA_W bits, fully addressed, with no aliasing and no wrap logic.
REQ-012 States SHALL be IDLE, WAIT and RESPOND.
REQ-013 IDLE behaviour:
- Memory_ready = 0; Memory_databus = high-Z.
- On a rising edge with Memory_request = 1, latch address, writemode and (writes only) databus into addr_q/we_q/data_q.
- Load counter with WAIT_CYCLES.
- Go to WAIT if WAIT_CYCLES > 0, else RESPOND.
REQ-014 WAIT behaviour:
- Counter decrements each edge; at the edge where counter = 1, go to RESPOND.
- All bus inputs, including request, writemode and address changes, are ignored.
REQ-015 RESPOND lasts exactly one cycle:
- Memory_ready = 1.
- Read: Memory_databus = mem[addr_q] (combinational read of the array).
- Write: mem[addr_q] <= data_q on the edge ending RESPOND; databus stays high-Z.
- Next state is always IDLE.
REQ-016 Latency: a request accepted at edge k SHALL produce Memory_ready high between edges k+WAIT_CYCLES and k+WAIT_CYCLES+1 (WAIT_CYCLES=0: the cycle directly after edge k).
REQ-017 A request held high through RESPOND SHALL be accepted as a new transaction at the first IDLE edge; back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
REQ-018 A read immediately following a write to the same address SHALL return the newly written data.
REQ-019 The databus output enable SHALL equal (state==RESPOND && !we_q); the block SHALL never drive the bus in any other cycle.
REQ-020 The counter width SHALL be 4 bits; no underflow is possible because the counter is loaded only in IDLE.

Reset
REQ-021 rst_n low SHALL asynchronously force:
- state = IDLE, Memory_ready = 0, databus high-Z.
- counter, addr_q, we_q and data_q = 0.
REQ-022 Reset mid-transaction SHALL discard the pending write (no array update) and abort any read response.
REQ-023 Array contents SHALL NOT be reset.
REQ-024 The first acceptance SHALL occur on the first rising edge with rst_n high and request = 1.

Structure
REQ-025 Shared package bu2020_pkg SHALL hold:
- ADDR_W and DATA_W constants.
- mem_state_t enum (IDLE, WAIT, RESPOND).
REQ-026 Storage SHALL be the sub-module mem_array: single port, synchronous write, asynchronous read, no reset. Control FSM, counter and tri-state live in memory_responder.

Verification
REQ-027 Write 0xBEEF to 0x123, then read 0x123 (WAIT_CYCLES=2) -> ready pulses 2 cycles after each accept edge; bus reads 0xBEEF only in the read RESPOND cycle.
REQ-028 WAIT_CYCLES=0, write 0x0001 to 0xFFF then read 0xFFF with request held high -> ready every 2nd cycle; read returns 0x0001; top address accessible.
REQ-029 Write 0x1111 to 0x010; during WAIT change address to 0x020 and data to 0x2222 -> mem[0x010]=0x1111, mem[0x020] unchanged.
REQ-030 Assert rst_n low during WAIT of a write of 0xAAAA to 0x005 (prior value 0x5555) -> ready stays 0; bus high-Z; mem[0x005] still 0x5555 on readback.
REQ-031 Across all tests, check that Memory_databus is high-Z whenever state != RESPOND or we_q = 1; any driven value in those cycles fails the bench.
